pixel_scorer: RTL and testbench
===============================

PIXEL_SCORER -- requirements
Module: pixel_scorer

Interface
REQ-001 HRES SHALL be a parameter, default 320, giving the frame width in pixels.
REQ-002 VRES SHALL be a parameter, default 180, giving the frame height in pixels.
REQ-003 MAX_PIXEL_SCORE SHALL be a parameter, default 7, giving the score clamp value; PWIDTH = $clog2(MAX_PIXEL_SCORE).
REQ-004 Port clk_in SHALL be an input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst_in SHALL be an input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port start_in SHALL be an input, 1 bit: a pulse that arms scoring of the next frame.
REQ-007 Port valid_in SHALL be an input, 1 bit: qualifies the pixel inputs.
REQ-008 Port hcount_in SHALL be an input, $clog2(HRES) bits: pixel column.
REQ-009 Port vcount_in SHALL be an input, $clog2(VRES) bits: pixel row.
REQ-010 Port skeleton_bit_in SHALL be an input, 1 bit: the pixel belongs to the user skeleton.
REQ-011 Port dist_addr_out SHALL be an output, $clog2(HRES*VRES) bits: read address to the model distance BRAM.
REQ-012 Port dist_data_in SHALL be an input, 5 bits: distance (0-31) to the model skeleton, returned by the BRAM.
REQ-013 Port valid_out SHALL be an output, 1 bit: qualifies the scored-pixel outputs.
REQ-014 Port skeleton_bit_out SHALL be an output, 1 bit: skeleton_bit_in delayed to align with the score.
REQ-015 Port pixel_score_out SHALL be an output, PWIDTH+1 bits: the clamped per-pixel score fed to the downstream scorer.
REQ-016 Port is_last_pixel_out SHALL be an output, 1 bit: marks the final pixel of the scored frame.
REQ-017 Port busy_out SHALL be an output, 1 bit: high while a frame is armed, in progress, or draining.

Function
REQ-018 Address SHALL be computed as dist_addr_out = vcount_in*HRES + hcount_in and registered 1 cycle after an accepted pixel.
REQ-019 BRAM read latency SHALL be fixed at 2 cycles after dist_addr_out is presented.
REQ-020 pixel_score_out SHALL be min(dist_data_in >> 2, MAX_PIXEL_SCORE), registered.
REQ-021 End-to-end latency from an accepted valid_in to its valid_out SHALL be exactly 4 cycles, fully pipelined, and SHALL accept one pixel per cycle.
REQ-022 skeleton_bit_out and is_last_pixel_out SHALL be delay-matched to pixel_score_out.
REQ-023 The FSM SHALL have the states IDLE, ARMED, SCAN, and DRAIN.
REQ-024 IDLE SHALL go to ARMED when start_in is high; all pixels are ignored in IDLE.
REQ-025 ARMED SHALL go to SCAN on valid_in with hcount_in=0 and vcount_in=0, and that pixel SHALL be accepted; all other pixels are ignored in ARMED.
REQ-026 In SCAN, every valid_in with hcount_in<HRES and vcount_in<VRES SHALL be accepted; out-of-range coordinates SHALL be ignored, with no output and no address update.
REQ-027 In SCAN, an accepted pixel at (HRES-1, VRES-1) SHALL carry is_last_pixel and cause a transition to DRAIN.
REQ-028 DRAIN SHALL return to IDLE in the cycle after the is_last_pixel_out pulse; pixels are ignored in DRAIN.
REQ-029 start_in SHALL be ignored in ARMED, SCAN, and DRAIN; start_in arriving in the same cycle as the DRAIN-to-IDLE transition SHALL also be ignored.
REQ-030 is_last_pixel_out SHALL pulse exactly once per scored frame, for 1 cycle, coincident with valid_out.
REQ-031 busy_out SHALL be high in ARMED, SCAN, and DRAIN, and low in IDLE.
REQ-032 When no pixel is accepted, valid_out SHALL be 0 for that pipeline slot; bubbles in valid_in SHALL propagate as bubbles.

Reset
REQ-033 While rst_in is high, the FSM SHALL be IDLE and all pipeline valid bits SHALL be 0.
REQ-034 While rst_in is high, valid_out, skeleton_bit_out, is_last_pixel_out, and busy_out SHALL be 0, and pixel_score_out and dist_addr_out SHALL be 0.
REQ-035 A reset asserted mid-frame SHALL discard all in-flight pixels, with no valid_out and no is_last_pixel_out after release.
REQ-036 After reset, a new start_in SHALL be required before any output is produced.

Verification
REQ-037 Full frame test: start_in, then a 320x180 raster with valid_in always high, BRAM model returns distance 13 everywhere -> 57600 valid_out pulses, each with pixel_score_out=3; is_last_pixel_out appears only on the last, 4 cycles after pixel (319,179); busy_out falls 1 cycle later.
REQ-038 Clamp and address test: distances 0, 3, 4, 27, 31 at addresses 0, 1, 2, 320, 57599 -> scores 0, 0, 1, 6, 7, and dist_addr_out values match vcount*320+hcount.
REQ-039 No-arm test: a raster with no start_in -> valid_out stays 0; start_in given mid-frame at (100,50) -> scoring begins at the next (0,0).
REQ-040 Bubble and out-of-range test: random valid_in gaps and pixels at (320,0) and (0,180) -> those pixels produce no output; in-range pixels keep 4-cycle latency and order; skeleton_bit_out matches the input pattern.
REQ-041 Reset test: rst_in asserted asynchronously at pixel (200,90) for 3 cycles -> all outputs 0 immediately; no is_last_pixel_out; next start_in plus full frame -> 57600 outputs.

Source files
------------

// File: rtl/pixel_scorer_if.sv
// Pixel-stream and distance-BRAM signals between a raster source and pixel_scorer.
// The master side drives pixels and returns BRAM data; the slave side is the scorer.
interface pixel_scorer_if #(
  parameter int unsigned HRES            = 320,
  parameter int unsigned VRES            = 180,
  parameter int unsigned MAX_PIXEL_SCORE = 7
);
  localparam int unsigned HW     = $clog2(HRES);
  localparam int unsigned VW     = $clog2(VRES);
  localparam int unsigned AW     = $clog2(HRES * VRES);
  localparam int unsigned PWIDTH = $clog2(MAX_PIXEL_SCORE);

  logic              start_in;
  logic              valid_in;
  logic [HW-1:0]     hcount_in;
  logic [VW-1:0]     vcount_in;
  logic              skeleton_bit_in;
  logic [AW-1:0]     dist_addr_out;
  logic [4:0]        dist_data_in;
  logic              valid_out;
  logic              skeleton_bit_out;
  logic [PWIDTH:0]   pixel_score_out;
  logic              is_last_pixel_out;
  logic              busy_out;

  modport slave (
    input  start_in, valid_in, hcount_in, vcount_in, skeleton_bit_in, dist_data_in,
    output dist_addr_out, valid_out, skeleton_bit_out, pixel_score_out, is_last_pixel_out,
           busy_out
  );

  modport master (
    output start_in, valid_in, hcount_in, vcount_in, skeleton_bit_in, dist_data_in,
    input  dist_addr_out, valid_out, skeleton_bit_out, pixel_score_out, is_last_pixel_out,
           busy_out
  );
endinterface

// File: rtl/pixel_scorer.sv
// Scores one armed frame: looks up each pixel's distance to the model skeleton in a
// 2-cycle BRAM and emits a clamped score 4 cycles after the pixel was accepted.
module pixel_scorer #(
  parameter int unsigned HRES            = 320,
  parameter int unsigned VRES            = 180,
  parameter int unsigned MAX_PIXEL_SCORE = 7
) (
  input  logic          clk_in,
  input  logic          rst_in,
  pixel_scorer_if.slave bus
);
  localparam int unsigned HW     = $clog2(HRES);
  localparam int unsigned VW     = $clog2(VRES);
  localparam int unsigned AW     = $clog2(HRES * VRES);
  localparam int unsigned PWIDTH = $clog2(MAX_PIXEL_SCORE);
  localparam int unsigned SW     = PWIDTH + 1;
  localparam logic [HW-1:0] HLAST = HW'(HRES - 1);
  localparam logic [VW-1:0] VLAST = VW'(VRES - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StScan, StDrain} state_e;

  state_e          r_state, w_state_next;
  logic            w_in_range, w_origin, w_corner, w_accept;
  logic [AW-1:0]   w_addr, r_addr;
  logic [4:0]      w_dist_q;
  logic [SW-1:0]   w_score, r_score;
  logic            r_v1, r_v2, r_v3;
  logic            r_s1, r_s2, r_s3;
  logic            r_l1, r_l2, r_l3;
  logic            r_valid_out, r_skel_out, r_last_out;

  assign w_in_range = bus.valid_in && (bus.hcount_in <= HLAST) && (bus.vcount_in <= VLAST);
  assign w_origin   = (bus.hcount_in == '0) && (bus.vcount_in == '0);
  assign w_corner   = (bus.hcount_in == HLAST) && (bus.vcount_in == VLAST);
  assign w_addr     = AW'(bus.vcount_in) * AW'(HRES) + AW'(bus.hcount_in);

  // Quarter-resolution distance, saturated at the clamp value.
  assign w_dist_q = bus.dist_data_in >> 2;
  assign w_score  = (32'(w_dist_q) > MAX_PIXEL_SCORE) ? SW'(MAX_PIXEL_SCORE) : SW'(w_dist_q);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start_in) w_state_next = StArmed;
      end
      StArmed: begin
        if (bus.valid_in && w_origin) begin
          w_accept     = 1'b1;
          w_state_next = StScan;
        end
      end
      StScan: begin
        if (w_in_range) begin
          w_accept = 1'b1;
          if (w_corner) w_state_next = StDrain;
        end
      end
      StDrain: begin
        // Leave only after the last pixel has been emitted; start_in is not looked at here.
        if (r_last_out) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_v3        <= 1'b0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_l1        <= 1'b0;
      r_l2        <= 1'b0;
      r_l3        <= 1'b0;
      r_valid_out <= 1'b0;
      r_skel_out  <= 1'b0;
      r_last_out  <= 1'b0;
      r_score     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_addr <= w_addr;
      r_v1        <= w_accept;
      r_s1        <= w_accept && bus.skeleton_bit_in;
      r_l1        <= w_accept && w_corner;
      r_v2        <= r_v1;
      r_s2        <= r_s1;
      r_l2        <= r_l1;
      // Stage 3 lines up with the BRAM data for the address issued two cycles earlier.
      r_v3        <= r_v2;
      r_s3        <= r_s2;
      r_l3        <= r_l2;
      r_valid_out <= r_v3;
      r_skel_out  <= r_s3;
      r_last_out  <= r_l3;
      r_score     <= r_v3 ? w_score : '0;
    end
  end

  assign bus.dist_addr_out     = r_addr;
  assign bus.valid_out         = r_valid_out;
  assign bus.skeleton_bit_out  = r_skel_out;
  assign bus.is_last_pixel_out = r_last_out;
  assign bus.pixel_score_out   = r_score;
  assign bus.busy_out          = (r_state != StIdle);
endmodule

// File: tb/tb_pixel_scorer.sv
// Bench for pixel_scorer: directed frames with random data, checked cycle by cycle against
// a frame-level reference model and a 2-cycle BRAM model.
module tb_pixel_scorer;
  localparam int HRES = 320;
  localparam int VRES = 180;
  localparam int MAXS = 7;
  localparam int NPIX = HRES * VRES;
  localparam int HW   = $clog2(HRES);
  localparam int VW   = $clog2(VRES);
  localparam int INF  = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pixel_scorer_if #(.HRES(HRES), .VRES(VRES), .MAX_PIXEL_SCORE(MAXS)) bus ();

  pixel_scorer #(.HRES(HRES), .VRES(VRES), .MAX_PIXEL_SCORE(MAXS)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  logic [4:0] mem [NPIX];
  logic [4:0] b1, b2;
  always @(posedge clk) begin
    b1 <= mem[bus.dist_addr_out];
    b2 <= b1;
  end
  assign bus.dist_data_in = b2;

  typedef struct {
    int         due;
    int         addr;
    logic [3:0] score;
    logic       skel;
    logic       last;
  } exp_t;

  exp_t oq[$];
  exp_t aq[$];
  int   pcount = 0;
  int   tests = 0;
  int   fails = 0;
  int   busy_from = INF;
  int   busy_to = INF;
  int   phase = 0;  // 0 idle, 1 armed, 2 scanning, 3 draining
  int   cur_addr = 0;
  int   n_out = 0;
  int   n_last = 0;

  always @(posedge clk) pcount <= pcount + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, pcount);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic ev;
    if (rst) begin
      chk("rst_valid", 32'(bus.valid_out), 0);
      chk("rst_last", 32'(bus.is_last_pixel_out), 0);
      chk("rst_skel", 32'(bus.skeleton_bit_out), 0);
      chk("rst_busy", 32'(bus.busy_out), 0);
      chk("rst_score", 32'(bus.pixel_score_out), 0);
      chk("rst_addr", 32'(bus.dist_addr_out), 0);
    end else begin
      if (aq.size() > 0 && aq[0].due == pcount) begin
        cur_addr = aq[0].addr;
        void'(aq.pop_front());
      end
      chk("addr", 32'(bus.dist_addr_out), cur_addr);
      ev = (oq.size() > 0) && (oq[0].due == pcount);
      chk("valid_out", 32'(bus.valid_out), 32'(ev));
      if (ev) begin
        e = oq.pop_front();
        chk("score", 32'(bus.pixel_score_out), 32'(e.score));
        chk("skel", 32'(bus.skeleton_bit_out), 32'(e.skel));
        chk("last", 32'(bus.is_last_pixel_out), 32'(e.last));
      end else begin
        chk("last_idle", 32'(bus.is_last_pixel_out), 0);
      end
      if (bus.valid_out) n_out++;
      if (bus.is_last_pixel_out) n_last++;
      chk("busy", 32'(bus.busy_out), 32'(pcount >= busy_from && pcount < busy_to));
    end
  end

  // Drive one cycle of inputs and update the frame-level model.
  task automatic cyc(input logic st, input logic v, input int h, input int vc, input logic sk);
    int   m;
    bit   acc;
    bit   lst;
    bit   idle;
    int   a;
    int   s;
    exp_t e;
    m   = pcount;
    acc = 0;
    lst = 0;
    bus.start_in        = st;
    bus.valid_in        = v;
    bus.hcount_in       = HW'(h);
    bus.vcount_in       = VW'(vc);
    bus.skeleton_bit_in = sk;
    idle = !(m >= busy_from && m < busy_to);
    if (idle) begin
      if (st) begin
        busy_from = m + 1;
        busy_to   = INF;
        phase     = 1;
      end
    end else if (phase == 1) begin
      if (v && h == 0 && vc == 0) begin
        acc   = 1;
        phase = 2;
      end
    end else if (phase == 2) begin
      if (v && h < HRES && vc < VRES) begin
        acc = 1;
        if (h == HRES - 1 && vc == VRES - 1) begin
          lst     = 1;
          phase   = 3;
          busy_to = m + 5;
        end
      end
    end
    if (acc) begin
      a = vc * HRES + h;
      s = int'(mem[a]) / 4;
      if (s > MAXS) s = MAXS;
      e.due   = m + 4;
      e.addr  = a;
      e.score = 4'(s);
      e.skel  = sk;
      e.last  = lst;
      oq.push_back(e);
      e.due = m + 1;
      aq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 16; i++) begin
      if (pcount >= busy_to && oq.size() == 0) break;
      cyc(0, 0, 0, 0, 0);
    end
    chk("drain_pending", oq.size(), 0);
    chk("drain_idle", 32'(bus.busy_out), 0);
  endtask

  task automatic do_reset(input int ncyc);
    #1 rst = 1'b1;
    bus.start_in = 1'b0;
    bus.valid_in = 1'b0;
    oq.delete();
    aq.delete();
    busy_from = INF;
    busy_to   = INF;
    phase     = 0;
    cur_addr  = 0;
    #1;
    chk("async_valid", 32'(bus.valid_out), 0);
    chk("async_busy", 32'(bus.busy_out), 0);
    chk("async_addr", 32'(bus.dist_addr_out), 0);
    chk("async_last", 32'(bus.is_last_pixel_out), 0);
    repeat (ncyc) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int h;
    int vc;
    bus.start_in        = 1'b0;
    bus.valid_in        = 1'b0;
    bus.hcount_in       = '0;
    bus.vcount_in       = '0;
    bus.skeleton_bit_in = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[i] = 5'($urandom);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(3);

    // Mid-frame reset discards in-flight pixels; nothing comes out without a new start.
    cyc(1, 0, 0, 0, 0);
    for (int x = 0; x < 12; x++) cyc(0, 1, x, 0, 1'($urandom));
    for (int x = 195; x < 200; x++) cyc(0, 1, x, 90, 1'($urandom));
    bus.valid_in  = 1'b1;
    bus.hcount_in = HW'(200);
    bus.vcount_in = VW'(90);
    do_reset(3);
    n_last = 0;
    for (int x = 0; x < 10; x++) cyc(0, 1, x, 0, 1);
    cyc(0, 1, HRES - 1, VRES - 1, 1);
    idle_cycles(8);
    chk("post_rst_no_last", n_last, 0);

    // No arm, then start mid-frame; also exercises clamp and address values.
    mem[0] = 5'd0;
    mem[1] = 5'd3;
    mem[2] = 5'd4;
    mem[320] = 5'd27;
    mem[NPIX-1] = 5'd31;
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 5, 5, 0);
    cyc(0, 1, HRES - 1, VRES - 1, 1);
    cyc(1, 1, 100, 50, 1);
    cyc(0, 1, 101, 50, 1);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 2, 0, 1);
    cyc(0, 1, 0, 1, 1);
    cyc(0, 1, HRES - 1, VRES - 1, 0);
    for (int i = 0; i < 10 && pcount < busy_to - 1; i++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);  // lands on the DRAIN-to-IDLE cycle
    drain();
    cyc(0, 1, 0, 0, 1);
    idle_cycles(6);

    // Bubbles, out-of-range coordinates and stray starts while scanning.
    for (int i = 0; i < NPIX; i++) mem[i] = 5'($urandom);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, HRES, 0, 1);
    cyc(0, 1, 0, VRES, 1);
    for (int i = 0; i < 400; i++) begin
      h  = int'($urandom_range(HRES + 10, 0));
      vc = int'($urandom_range(VRES + 5, 0));
      if (i % 50 == 7) begin
        h  = HRES;
        vc = 0;
      end
      if (i % 50 == 23) begin
        h  = 0;
        vc = VRES;
      end
      cyc(($urandom % 16) == 0, ($urandom % 4) != 0, h, vc, 1'($urandom));
    end
    cyc(0, 1, HRES - 1, VRES - 1, 1);
    drain();

    // Full raster with constant distance 13.
    for (int i = 0; i < NPIX; i++) mem[i] = 5'd13;
    n_out  = 0;
    n_last = 0;
    cyc(1, 0, 0, 0, 0);
    for (int y = 0; y < VRES; y++)
      for (int x = 0; x < HRES; x++) cyc(0, 1, x, y, 1'($urandom));
    drain();
    chk("frame_outputs", n_out, NPIX);
    chk("frame_last_count", n_last, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
